// File: rtl/cam_pwr_pkg.sv
// Shared camera power sequencing types and default timing, used by both the
// power-on and power-down sequencers.
package cam_pwr_pkg;

  typedef enum logic [2:0] {
    ST_ON,
    ST_DRAIN,
    ST_RST,
    ST_PWDN,
    ST_OFF,
    ST_WAKE
  } pwr_state_t;

  // Cycle counts at 24 MHz: 1 ms drain limit, 1.3 ms reset hold, 5 ms pwdn hold
  localparam int DEF_DRAIN_TIMEOUT = 24000;
  localparam int DEF_RST_HOLD      = 31200;
  localparam int DEF_PWDN_HOLD     = 120000;
  localparam int CNT_MIN_W         = 20;

  typedef struct packed {
    logic sccb_hold;
    logic cam_rst_force;
    logic cam_pwdn_force;
    logic pd_ack;
    logic pd_busy;
    logic pu_req;
  } pwr_out_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < CNT_MIN_W) ? CNT_MIN_W : w;
  endfunction

  // Forcing outputs nest so they can only release pwdn, then rst, then hold
  function automatic pwr_out_t decode_outputs(input pwr_state_t s);
    pwr_out_t o;
    o = '0;
    case (s)
      ST_DRAIN: begin
        o.sccb_hold = 1'b1;
        o.pd_busy   = 1'b1;
      end
      ST_RST: begin
        o.sccb_hold     = 1'b1;
        o.cam_rst_force = 1'b1;
        o.pd_busy       = 1'b1;
      end
      ST_PWDN: begin
        o.sccb_hold      = 1'b1;
        o.cam_rst_force  = 1'b1;
        o.cam_pwdn_force = 1'b1;
        o.pd_busy        = 1'b1;
      end
      ST_OFF: begin
        o.sccb_hold      = 1'b1;
        o.cam_rst_force  = 1'b1;
        o.cam_pwdn_force = 1'b1;
        o.pd_ack         = 1'b1;
      end
      ST_WAKE: o.pu_req = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pwr_delay_cnt.sv
// Saturating cycle counter for the power sequencers; clear wins over enable.
module pwr_delay_cnt #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/camera_power_down_seq.sv
// Camera power-down sequencer: drain SCCB, hold resetb low, then pwdn high,
// and hand back to the power-on path through a one-cycle wake request.
module camera_power_down_seq
  import cam_pwr_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int RST_HOLD      = DEF_RST_HOLD,
  parameter int PWDN_HOLD     = DEF_PWDN_HOLD
) (
  input  logic clk_24M,
  input  logic reset,
  input  logic pd_req,
  input  logic sccb_busy,
  output logic sccb_hold,
  output logic cam_rst_force,
  output logic cam_pwdn_force,
  output logic pd_ack,
  output logic pd_busy,
  output logic drain_timeout,
  output logic pu_req
);

  localparam int CNT_W = cnt_width(DRAIN_TIMEOUT, RST_HOLD, PWDN_HOLD);

  pwr_state_t       state;
  pwr_state_t       next_state;
  pwr_out_t         outs;
  pwr_out_t         next_outs;
  logic [CNT_W-1:0] count;
  logic             clear_cnt;
  logic             run_cnt;
  logic             set_timeout;
  logic             clr_timeout;

  pwr_delay_cnt #(.WIDTH(CNT_W)) u_cnt (
    .clk    (clk_24M),
    .reset  (reset),
    .clear  (clear_cnt),
    .enable (run_cnt),
    .count  (count)
  );

  // Outputs are registered from next_state so they line up with the state register
  always_ff @(posedge clk_24M) begin
    if (reset) begin
      state         <= ST_ON;
      outs          <= '0;
      drain_timeout <= 1'b0;
    end else begin
      state <= next_state;
      outs  <= next_outs;
      if (clr_timeout) begin
        drain_timeout <= 1'b0;
      end else if (set_timeout) begin
        drain_timeout <= 1'b1;
      end
    end
  end

  // An idle bus in the last drain cycle takes priority over the timeout
  always_comb begin
    next_state  = state;
    set_timeout = 1'b0;
    clr_timeout = 1'b0;
    case (state)
      ST_ON: begin
        if (pd_req) begin
          next_state  = ST_DRAIN;
          clr_timeout = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!sccb_busy) begin
          next_state = ST_RST;
        end else if (count == CNT_W'(DRAIN_TIMEOUT - 1)) begin
          next_state  = ST_RST;
          set_timeout = 1'b1;
        end
      end
      ST_RST:  if (count == CNT_W'(RST_HOLD - 1))  next_state = ST_PWDN;
      ST_PWDN: if (count == CNT_W'(PWDN_HOLD - 1)) next_state = ST_OFF;
      ST_OFF:  if (!pd_req) next_state = ST_WAKE;
      ST_WAKE: next_state = ST_ON;
      default: next_state = ST_ON;
    endcase
    clear_cnt = (next_state != state);
    run_cnt   = (state == ST_DRAIN) || (state == ST_RST) || (state == ST_PWDN);
    next_outs = decode_outputs(next_state);
  end

  assign sccb_hold      = outs.sccb_hold;
  assign cam_rst_force  = outs.cam_rst_force;
  assign cam_pwdn_force = outs.cam_pwdn_force;
  assign pd_ack         = outs.pd_ack;
  assign pd_busy        = outs.pd_busy;
  assign pu_req         = outs.pu_req;

endmodule
